// File: rtl/cs_resolve_221_pkg.sv
// Shared types and defaults for the carry-save resolver.
package cs_resolve_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StRed
  } state_e;

  localparam int unsigned DefW = 8;
  localparam int unsigned DefM = 221;

  // 2^(W-1) < M bounds the (W+1)-bit sum below 4*M, so three subtractions always suffice.
  localparam int unsigned MaxSub = 3;

endpackage

// File: rtl/cs_resolve_221_if.sv
// Done/carry-save/result bundle between an exponentiation core and the resolver.
interface cs_resolve_221_if #(
  parameter int unsigned W = cs_resolve_pkg::DefW
);
  logic         dn;
  logic [0:W-1] xs;
  logic [0:W-1] xc;
  logic         busy;
  logic         vld;
  logic [0:W-1] y;
  logic         ovr;

  modport master (output dn, xs, xc, input busy, vld, y, ovr);
  modport slave  (input dn, xs, xc, output busy, vld, y, ovr);
endinterface

// File: rtl/cs_serial_add.sv
// One-bit full adder with a registered carry, synchronous clear and enable.
module cs_serial_add (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  logic carry_q;

  assign s_o = a_i ^ b_i ^ carry_q;
  assign c_o = (a_i & b_i) | (a_i & carry_q) | (b_i & carry_q);

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      carry_q <= 1'b0;
    end else if (en_i) begin
      carry_q <= c_o;
    end
  end

endmodule

// File: rtl/cs_resolve_221.sv
// Captures a carry-save pair on a rising dn, adds it bit-serially, then reduces mod M.
module cs_resolve_221
  import cs_resolve_pkg::*;
#(
  parameter int unsigned W = DefW,
  parameter int unsigned M = DefM
) (
  input logic             clk,
  input logic             rst,
  cs_resolve_221_if.slave cs_if
);

  localparam int unsigned     CntW    = $clog2(W + 1);
  localparam logic [W:0]      MVal    = (W + 1)'(M);
  localparam logic [CntW-1:0] CntInit = CntW'(W);

  state_e          state_q;
  logic [0:W-1]    a_q, b_q, y_q;
  logic [W:0]      sum_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      sub_cnt_q;
  logic            dn_q, busy_q, vld_q, ovr_q;
  logic            rise, add_en, add_clr, s_bit, c_next;

  assign rise    = cs_if.dn & ~dn_q;
  assign add_en  = (state_q == StAdd);
  assign add_clr = (state_q == StIdle) & rise;

  cs_serial_add u_add (
    .clk   (clk),
    .rst   (rst),
    .clr_i (add_clr),
    .en_i  (add_en),
    .a_i   (a_q[W-1]),
    .b_i   (b_q[W-1]),
    .s_o   (s_bit),
    .c_o   (c_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      sub_cnt_q <= '0;
      dn_q      <= 1'b1;  // a dn held high through reset must not look like a new request
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
      y_q       <= '0;
      ovr_q     <= 1'b0;
    end else begin
      dn_q  <= cs_if.dn;
      vld_q <= 1'b0;
      if (rise && busy_q) begin
        ovr_q <= 1'b1;
      end
      case (state_q)
        StIdle: begin
          if (rise) begin
            a_q       <= cs_if.xs;
            b_q       <= cs_if.xc;
            sum_q     <= '0;
            cnt_q     <= CntInit;
            sub_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= StAdd;
          end
        end
        StAdd: begin
          // Index W-1 is the LSB, so shifting toward it consumes one bit per cycle.
          a_q            <= {1'b0, a_q[0:W-2]};
          b_q            <= {1'b0, b_q[0:W-2]};
          sum_q[W-1:0]   <= {s_bit, sum_q[W-1:1]};
          cnt_q          <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            sum_q[W] <= c_next;
            state_q  <= StRed;
          end
        end
        StRed: begin
          if (sum_q >= MVal) begin
            sum_q     <= sum_q - MVal;
            sub_cnt_q <= sub_cnt_q + 1'b1;
          end else begin
            y_q     <= sum_q[W-1:0];
            vld_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (32'(sub_cnt_q) <= MaxSub);
    end
  end

  assign cs_if.busy = busy_q;
  assign cs_if.vld  = vld_q;
  assign cs_if.y    = y_q;
  assign cs_if.ovr  = ovr_q;

endmodule

// File: tb/tb_cs_resolve_221.sv
// Self-checking bench for cs_resolve_221 against an arithmetic model of (xs + xc) mod M.
module tb_cs_resolve_221;
  localparam int unsigned W = 8;
  localparam int unsigned M = 221;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  cs_resolve_221_if #(.W(W)) bus ();

  cs_resolve_221 #(.W(W), .M(M)) dut (
    .clk   (clk),
    .rst   (rst),
    .cs_if (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int model_y(input int a, input int b);
    return (a + b) % M;
  endfunction

  function automatic int model_lat(input int a, input int b);
    return W + 1 + (a + b) / M;
  endfunction

  task automatic do_reset();
    rst    = 1'b1;
    bus.dn = 1'b0;
    bus.xs = '0;
    bus.xc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one request now and returns #1 after the edge where vld is seen.
  task automatic run_one(input int a, input int b, output int lat, output int yv,
                         output bit got, output bit busy_ok);
    bus.dn  = 1'b1;
    bus.xs  = W'(a);
    bus.xc  = W'(b);
    got     = 1'b0;
    busy_ok = 1'b1;
    lat     = 0;
    yv      = -1;
    @(posedge clk);
    #1 bus.dn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!got && bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1 lat++;
      if (bus.vld === 1'b1) begin
        got = 1'b1;
        yv  = int'(bus.y);
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk);
    #1;
    n_chk++;
    if ({bus.busy, bus.vld, bus.ovr} !== 3'b000 || bus.y !== '0)
      $display("FAIL reset_state: busy=%b vld=%b ovr=%b y=%0d, required all zero",
               bus.busy, bus.vld, bus.ovr, bus.y);
    else n_pass++;
  endtask

  task automatic test_directed();
    int xa [5] = '{0, 100, 200, 221, 255};
    int xb [5] = '{0, 20, 100, 0, 255};
    int lat, yv;
    bit got, bok;
    for (int i = 0; i < 5; i++) begin
      run_one(xa[i], xb[i], lat, yv, got, bok);
      n_chk++;
      if (!got || yv != model_y(xa[i], xb[i]) || lat != model_lat(xa[i], xb[i]) || !bok)
        $display("FAIL directed_%0d_%0d: got=%0b y=%0d lat=%0d busy_ok=%0b, required y=%0d lat=%0d",
                 xa[i], xb[i], got, yv, lat, bok, model_y(xa[i], xb[i]), model_lat(xa[i], xb[i]));
      else n_pass++;
      @(posedge clk);
      #1;
      n_chk++;
      if (bus.vld !== 1'b0 || int'(bus.y) != model_y(xa[i], xb[i]) || bus.ovr !== 1'b0)
        $display("FAIL hold_after_vld_%0d: vld=%b y=%0d ovr=%b, required vld=0 y=%0d ovr=0",
                 i, bus.vld, bus.y, bus.ovr, model_y(xa[i], xb[i]));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int a, b, lat, yv, bad;
    bit got, bok;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      run_one(a, b, lat, yv, got, bok);
      n_chk++;
      if (!got || yv != model_y(a, b) || lat != model_lat(a, b) || !bok)
        $display("FAIL random_%0d (%0d+%0d): got=%0b y=%0d lat=%0d busy_ok=%0b, required y=%0d lat=%0d",
                 i, a, b, got, yv, lat, bok, model_y(a, b), model_lat(a, b));
      else n_pass++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int lat, yv;
    bit got, bok;
    run_one(17, 230, lat, yv, got, bok);
    // Next request issued in the very cycle vld is high.
    run_one(250, 240, lat, yv, got, bok);
    n_chk++;
    if (!got || yv != model_y(250, 240) || lat != model_lat(250, 240))
      $display("FAIL back_to_back: got=%0b y=%0d lat=%0d, required y=%0d lat=%0d",
               got, yv, lat, model_y(250, 240), model_lat(250, 240));
    else n_pass++;
  endtask

  task automatic test_collision();
    int lat, yv;
    bit got, bok;
    do_reset();
    @(posedge clk);
    #1 bus.dn = 1'b1;
    bus.xs = 8'd200;
    bus.xc = 8'd100;
    @(posedge clk);  // E0
    #1 bus.dn = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.dn = 1'b1;
    bus.xs = 8'd1;
    bus.xc = 8'd1;
    @(posedge clk);  // E3
    #1 bus.dn = 1'b0;
    lat = 3;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 lat++;
      if (bus.vld === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!got || int'(bus.y) != model_y(200, 100) || lat != model_lat(200, 100) || bus.ovr !== 1'b1)
      $display("FAIL collision: got=%0b y=%0d lat=%0d ovr=%b, required y=%0d lat=%0d ovr=1",
               got, bus.y, lat, bus.ovr, model_y(200, 100), model_lat(200, 100));
    else n_pass++;
    @(posedge clk);
    #1;
    run_one(1, 1, lat, yv, got, bok);
    n_chk++;
    if (!got || yv != model_y(1, 1) || lat != model_lat(1, 1) || bus.ovr !== 1'b1)
      $display("FAIL after_collision: got=%0b y=%0d lat=%0d ovr=%b, required y=%0d lat=%0d ovr=1",
               got, yv, lat, bus.ovr, model_y(1, 1), model_lat(1, 1));
    else n_pass++;
    do_reset();
    #1;
    n_chk++;
    if (bus.ovr !== 1'b0) $display("FAIL ovr_cleared: ovr=%b, required 0", bus.ovr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int vld_seen;
    do_reset();
    @(posedge clk);
    #1 bus.dn = 1'b1;
    bus.xs = 8'd255;
    bus.xc = 8'd255;
    @(posedge clk);  // E0
    #1 bus.dn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);  // E4
    #1;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.vld !== 1'b0)
      $display("FAIL reset_mid_add: busy=%b vld=%b, required 0 0", bus.busy, bus.vld);
    else n_pass++;
    rst = 1'b0;
    vld_seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1 if (bus.vld !== 1'b0 || bus.busy !== 1'b0) vld_seen++;
    end
    n_chk++;
    if (vld_seen != 0 || bus.y !== '0)
      $display("FAIL reset_mid_quiet: active_cycles=%0d y=%0d, required 0 0", vld_seen, bus.y);
    else n_pass++;
  endtask

  task automatic test_dn_held();
    int active, lat, yv;
    bit got, bok;
    rst    = 1'b1;
    bus.dn = 1'b1;
    bus.xs = 8'd100;
    bus.xc = 8'd20;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    active = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (bus.busy !== 1'b0 || bus.vld !== 1'b0) active++;
    end
    n_chk++;
    if (active != 0) $display("FAIL dn_held_no_capture: active_cycles=%0d, required 0", active);
    else n_pass++;
    bus.dn = 1'b0;
    @(posedge clk);
    #1;
    run_one(100, 20, lat, yv, got, bok);
    n_chk++;
    if (!got || yv != model_y(100, 20) || lat != model_lat(100, 20))
      $display("FAIL dn_held_recapture: got=%0b y=%0d lat=%0d, required y=%0d lat=%0d",
               got, yv, lat, model_y(100, 20), model_lat(100, 20));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    test_dn_held();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
